retospect_cfg_sequencer: RTL and testbench

RETOSPECT_CFG_SEQUENCER -- requirements
Module: retospect_cfg_sequencer

---
 rtl/retospect_pkg.sv | 8 +
 rtl/retospect_cfg_sequencer.sv | 84 ++++++++
 tb/tb_retospect_cfg_sequencer.sv | 172 +++++++++++++++++
 3 files changed

// File: rtl/retospect_pkg.sv
// retospect_pkg: shared FSM encoding and config-chain geometry for the retospect sequencer
package retospect_pkg;
  localparam int CLOCKBOX_BITS = 48;
  localparam int CELL_BITS = 19;
  localparam int N_CELLS = 25;
  localparam int CHAIN_LEN_DEF = CLOCKBOX_BITS + N_CELLS * CELL_BITS;
  typedef enum logic [2:0] {IDLE, LOAD, SHIFT, ARM, FIN} state_e;
endpackage

// File: rtl/retospect_cfg_sequencer.sv
// retospect_cfg_sequencer: streams host bytes LSB-first into the config chain, then pulses reset_nn and done
module retospect_cfg_sequencer
  import retospect_pkg::*;
#(
  parameter int CHAIN_LEN = CHAIN_LEN_DEF,
  parameter int CNT_W = 10
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic       abort,
  input  logic       byte_valid,
  input  logic [7:0] byte_data,
  output logic       byte_ready,
  input  logic       bs_ret,
  output logic       config_en,
  output logic       bs_in,
  output logic       reset_nn,
  output logic       busy,
  output logic       done,
  output logic       ret_parity
);
  state_e state_q, state_d;
  logic [CNT_W-1:0] bit_cnt_q, bit_cnt_d;
  logic [2:0] bib_q, bib_d;
  logic [7:0] sreg_q, sreg_d;
  logic par_q, par_d;
  logic last_bit;
  assign last_bit = bit_cnt_q == CNT_W'(CHAIN_LEN - 1);
  always_ff @(posedge clk or posedge reset)
    if (reset) state_q <= IDLE;
    else state_q <= state_d;
  // abort outranks both the byte handshake and the end-of-chain exit
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    state_d = start ? LOAD : IDLE;
      LOAD:    state_d = abort ? IDLE : byte_valid ? SHIFT : LOAD;
      SHIFT:   state_d = abort ? IDLE : last_bit ? ARM : (&bib_q) ? LOAD : SHIFT;
      ARM:     state_d = FIN;
      FIN:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end
  always_comb begin
    byte_ready = state_q == LOAD;
    config_en = state_q == SHIFT;
    bs_in = config_en & sreg_q[0];
    reset_nn = state_q == ARM;
    done = state_q == FIN;
    busy = state_q != IDLE;
  end
  assign ret_parity = par_q;
  always_comb begin
    bit_cnt_d = bit_cnt_q;
    bib_d = bib_q;
    sreg_d = sreg_q;
    par_d = par_q;
    if (state_q == IDLE && start) begin
      bit_cnt_d = '0;
      bib_d = '0;
      par_d = 1'b0;
    end else if (state_q == LOAD && byte_valid) begin
      sreg_d = byte_data;
    end else if (state_q == SHIFT) begin
      sreg_d = sreg_q >> 1;
      bit_cnt_d = bit_cnt_q + 1'b1;
      bib_d = bib_q + 1'b1;
      par_d = par_q ^ bs_ret;
    end
  end
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      bit_cnt_q <= '0;
      bib_q <= '0;
      sreg_q <= '0;
      par_q <= 1'b0;
    end else begin
      bit_cnt_q <= bit_cnt_d;
      bib_q <= bib_d;
      sreg_q <= sreg_d;
      par_q <= par_d;
    end
endmodule

// File: tb/tb_retospect_cfg_sequencer.sv
// tb_retospect_cfg_sequencer: randomized loads against a bit-stream model, plus a full-length default chain
module tb_retospect_cfg_sequencer;
  localparam int N = 12;
  logic clk = 0, reset = 1;
  logic start = 0, abort = 0, byte_valid = 0, bs_ret = 0;
  logic [7:0] byte_data = 0;
  logic byte_ready, config_en, bs_in, reset_nn, busy, done, ret_parity;
  logic b_start = 0, b_abort = 0, b_valid = 0, b_ret = 0;
  logic [7:0] b_data = 0;
  logic b_ready, b_config_en, b_bs_in, b_reset_nn, b_busy, b_done, b_parity;
  int n_vec = 0, n_err = 0;
  always #5 clk = ~clk;
  retospect_cfg_sequencer #(.CHAIN_LEN(N), .CNT_W(4)) dut (
    .clk(clk), .reset(reset), .start(start), .abort(abort), .byte_valid(byte_valid),
    .byte_data(byte_data), .byte_ready(byte_ready), .bs_ret(bs_ret), .config_en(config_en),
    .bs_in(bs_in), .reset_nn(reset_nn), .busy(busy), .done(done), .ret_parity(ret_parity));
  retospect_cfg_sequencer dut_full (
    .clk(clk), .reset(reset), .start(b_start), .abort(b_abort), .byte_valid(b_valid),
    .byte_data(b_data), .byte_ready(b_ready), .bs_ret(b_ret), .config_en(b_config_en),
    .bs_in(b_bs_in), .reset_nn(b_reset_nn), .busy(b_busy), .done(b_done), .ret_parity(b_parity));
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  // abort_at: >0 abort on that shift, <0 abort in the LOAD after byte 1, 0 none
  task automatic run_load(input int abort_at, input int stall_pct, input int stall_first,
                          input logic [N-1:0] ret_mask, input bit late_abort, input bit noise, input bit fixed);
    logic q_exp[$];
    logic q_got[$];
    logic [N-1:0] got_v, exp_v;
    int shifts = 0, hs = 0, rnn = 0, dn = 0, cyc = 0, stall = 0;
    bit pend = 0, prev_rnn = 0, overlap = 0;
    logic par = 0;
    logic [7:0] d;
    start = 1;
    @(negedge clk);
    start = 0;
    check("par_clr", 32'(ret_parity), 0);
    forever begin
      cyc++;
      if (pend) begin
        check("abort_idle", 32'(busy), 0);
        break;
      end
      if (prev_rnn) check("done_after_arm", 32'(done), 1);
      prev_rnn = reset_nn;
      rnn += 32'(reset_nn);
      dn += 32'(done);
      overlap |= config_en & byte_ready;
      if (config_en) q_got.push_back(bs_in);
      if (done || cyc > 200) break;
      abort = 0;
      bs_ret = 1'($urandom);
      start = noise && ($urandom_range(0, 2) == 0);
      byte_valid = 1'($urandom);
      byte_data = 8'($urandom);
      if (config_en) begin
        bs_ret = ret_mask[shifts];
        shifts++;
        par ^= bs_ret;
        if (shifts == abort_at) begin
          abort = 1;
          pend = 1;
        end
      end
      if (byte_ready) begin
        if (abort_at < 0 && hs == 1) begin
          abort = 1;
          pend = 1;
        end
        d = fixed ? (hs == 0 ? 8'hA5 : 8'h0F) : 8'($urandom);
        byte_valid = (hs == 1 && stall < stall_first) ? 1'b0 : 1'($urandom_range(0, 99) >= stall_pct);
        if (hs == 1 && stall < stall_first) stall++;
        byte_data = d;
        if (byte_valid && !pend) begin
          hs++;
          for (int i = 0; i < 8; i++) q_exp.push_back(d[i]);
        end
      end
      if (late_abort && reset_nn) abort = 1;
      @(negedge clk);
    end
    start = 0;
    abort = 0;
    byte_valid = 0;
    if (cyc > 200) check("timeout", 32'(cyc), 0);
    check("no_overlap", 32'(overlap), 0);
    got_v = '0;
    exp_v = '0;
    for (int i = 0; i < N; i++)
      if (i < q_got.size()) begin
        got_v[i] = q_got[i];
        exp_v[i] = i < q_exp.size() ? q_exp[i] : 1'b0;
      end
    check("bits", 32'(got_v), 32'(exp_v));
    if (pend) begin
      check("abort_shifts", 32'(q_got.size()), 32'(abort_at > 0 ? abort_at : 8));
      check("abort_rnn", 32'(rnn), 0);
      check("abort_done", 32'(dn), 0);
      @(negedge clk);
      check("abort_quiet", 32'({done, reset_nn, busy}), 0);
    end else begin
      if (fixed) check("seq_a5_0f", 32'(got_v), 32'h0FA5);
      check("shifts", 32'(q_got.size()), N);
      check("bytes", 32'(hs), (N + 7) / 8);
      check("rnn", 32'(rnn), 1);
      check("done", 32'(dn), 1);
      check("parity", 32'(ret_parity), 32'(par));
      if (stall_pct == 0 && stall_first == 0) check("cycles", 32'(cyc), N + (N + 7) / 8 + 2);
      @(negedge clk);
      check("idle", 32'({done, reset_nn, config_en, busy}), 0);
      check("par_hold", 32'(ret_parity), 32'(par));
    end
    repeat (2) @(negedge clk);
  endtask
  initial begin
    int ben = 0, bhs = 0, bdn = 0, bcyc = 0;
    repeat (2) @(negedge clk);
    check("rst_outs", 32'({byte_ready, config_en, bs_in, reset_nn, busy, done, ret_parity}), 0);
    check("rst_outs_full", 32'({b_ready, b_config_en, b_bs_in, b_reset_nn, b_busy, b_done, b_parity}), 0);
    reset = 0;
    @(negedge clk);
    run_load(0, 0, 0, 12'b000100100100, 0, 0, 1);
    run_load(0, 0, 5, 12'(($urandom)), 0, 0, 0);
    run_load(6, 0, 0, 12'(($urandom)), 0, 0, 0);
    run_load(N, 0, 0, 12'(($urandom)), 0, 0, 0);
    run_load(-1, 0, 0, 12'(($urandom)), 0, 0, 0);
    run_load(0, 0, 0, 12'(($urandom)), 1, 1, 0);
    start = 1;
    @(negedge clk);
    start = 0;
    byte_valid = 1;
    byte_data = 8'hFF;
    @(negedge clk);
    byte_valid = 0;
    check("pre_rst_shift", 32'(config_en), 1);
    reset = 1;
    #1;
    check("async_rst", 32'({config_en, busy}), 0);
    @(negedge clk);
    reset = 0;
    @(negedge clk);
    run_load(0, 0, 0, 12'(($urandom)), 0, 0, 0);
    for (int k = 0; k < 20; k++)
      run_load(($urandom_range(0, 3) == 0) ? int'($urandom_range(1, N)) : 0, int'($urandom_range(0, 60)),
               0, 12'(($urandom)), 1'($urandom), 1'($urandom), 0);
    b_start = 1;
    @(negedge clk);
    b_start = 0;
    b_valid = 1;
    while (bcyc < 2000) begin
      bcyc++;
      ben += 32'(b_config_en);
      bhs += 32'(b_ready & b_valid);
      bdn += 32'(b_done);
      if (!b_busy) break;
      b_data = 8'($urandom);
      b_ret = 1'($urandom);
      @(negedge clk);
    end
    b_valid = 0;
    if (bcyc >= 2000) check("full_timeout", 32'(bcyc), 0);
    check("full_shifts", 32'(ben), 523);
    check("full_bytes", 32'(bhs), 66);
    check("full_done", 32'(bdn), 1);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
